// File: rtl/result_sel_pipe.sv
// Registered N-channel result selector with fixed/round-robin grant and overflow status.
// One output register stage with valid/ready handshake; drain and reload can overlap for full throughput.
module result_sel_pipe #(
  parameter  int N_CH = 4,
  parameter  int DW   = 16,
  parameter  int CNTW = 8,
  localparam int SELW = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*(DW+1)-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  output logic [DW-1:0]          out_data,
  output logic                   out_ovf,
  output logic [SELW-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   ovf_clr,
  output logic                   ovf_sticky,
  output logic [CNTW-1:0]        ovf_cnt
);

  localparam logic [SELW:0]   LP_NCH     = (SELW+1)'(N_CH);
  localparam logic [CNTW-1:0] LP_CNT_MAX = '1;

  logic [DW:0]       w_ch [N_CH];
  logic [2*N_CH-1:0] w_dbl;
  logic [N_CH-1:0]   w_rot;
  logic [SELW-1:0]   w_rr_off;
  logic [SELW:0]     w_rr_sum;
  logic [SELW:0]     w_rr_wrap;
  logic [SELW-1:0]   w_rr_grant;
  logic              w_rr_valid;
  logic              w_sel_ok;
  logic [SELW-1:0]   w_grant;
  logic              w_grant_valid;
  logic              w_load;
  logic [DW:0]       w_slice;
  logic [SELW:0]     w_ptr_sum;
  logic [SELW-1:0]   w_ptr_next;

  logic [SELW-1:0]   r_ptr;
  logic [DW-1:0]     r_data;
  logic              r_ovf;
  logic [SELW-1:0]   r_ch;
  logic              r_valid;
  logic              r_sticky;
  logic [CNTW-1:0]   r_cnt;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign w_ch[gi] = in_data[gi*(DW+1) +: DW+1];
  end

  // Rotate valids so bit 0 is the channel at the RR pointer; the first set bit is the winner.
  assign w_dbl = {in_valid, in_valid} >> r_ptr;
  assign w_rot = w_dbl[N_CH-1:0];

  always_comb begin
    w_rr_off = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) w_rr_off = k[SELW-1:0];
    end
  end

  assign w_rr_valid = |in_valid;
  assign w_rr_sum   = {1'b0, r_ptr} + {1'b0, w_rr_off};
  assign w_rr_wrap  = w_rr_sum - LP_NCH;
  assign w_rr_grant = (w_rr_sum >= LP_NCH) ? w_rr_wrap[SELW-1:0] : w_rr_sum[SELW-1:0];

  assign w_sel_ok      = ({1'b0, sel} < LP_NCH);
  assign w_grant       = mode ? w_rr_grant : sel;
  assign w_grant_valid = mode ? w_rr_valid : (w_sel_ok ? in_valid[sel] : 1'b0);
  assign w_load        = (!r_valid || out_ready) && w_grant_valid;
  assign w_slice       = w_ch[w_grant];

  assign w_ptr_sum  = {1'b0, w_grant} + 1'b1;
  assign w_ptr_next = (w_ptr_sum == LP_NCH) ? '0 : w_ptr_sum[SELW-1:0];

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
    assign in_ready[gi] = w_load && (w_grant == SELW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_data   <= '0;
      r_ovf    <= 1'b0;
      r_ch     <= '0;
      r_valid  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_load) begin
        r_data  <= w_slice[DW-1:0];
        r_ovf   <= w_slice[DW];
        r_ch    <= w_grant;
        r_valid <= 1'b1;
        r_ptr   <= w_ptr_next;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      // An overflowed accept takes priority over a simultaneous clear.
      if (w_load && w_slice[DW]) begin
        r_sticky <= 1'b1;
        r_cnt    <= ovf_clr ? CNTW'(1) : ((r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + 1'b1);
      end else if (ovf_clr) begin
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign out_data   = r_data;
  assign out_ovf    = r_ovf;
  assign out_ch     = r_ch;
  assign out_valid  = r_valid;
  assign ovf_sticky = r_sticky;
  assign ovf_cnt    = r_cnt;

endmodule

// File: tb/tb_result_sel_pipe.sv
// Self-checking bench for result_sel_pipe: vector table, hand sequences and random traffic
// against a behavioural model; a 3-channel instance covers out-of-range fixed select.
module tb_result_sel_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [67:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [1:0]  out_ch;
  logic        out_valid, out_ready, ovf_clr, ovf_sticky;
  logic [7:0]  ovf_cnt;

  logic [26:0] t_data;
  logic [2:0]  t_valid, t_ready;
  logic        t_mode;
  logic [1:0]  t_sel;
  logic [7:0]  t_out_data;
  logic        t_out_ovf;
  logic [1:0]  t_out_ch;
  logic        t_out_valid, t_out_ready, t_clr, t_sticky;
  logic [3:0]  t_cnt;

  result_sel_pipe #(.N_CH(4), .DW(16), .CNTW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ovf(out_ovf), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .ovf_clr(ovf_clr),
    .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt)
  );

  result_sel_pipe #(.N_CH(3), .DW(8), .CNTW(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(t_data), .in_valid(t_valid), .in_ready(t_ready),
    .mode(t_mode), .sel(t_sel), .out_data(t_out_data), .out_ovf(t_out_ovf), .out_ch(t_out_ch),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .ovf_clr(t_clr),
    .ovf_sticky(t_sticky), .ovf_cnt(t_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  int          m_ptr, m_ch, m_cnt;
  bit          m_valid, m_ovf, m_sticky;
  logic [15:0] m_data;
  logic [3:0]  last_rdy;

  typedef struct {
    bit          md;
    logic [1:0]  s;
    logic [3:0]  v;
    bit          ordy;
    logic [3:0]  e_rdy;
    bit          e_ov;
    logic [1:0]  e_ch;
    logic [15:0] e_data;
    bit          e_ovf;
    int          e_cnt;
  } vec_t;

  vec_t tbl[12];
  int   rr_exp[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ch = 0; m_cnt = 0;
    m_valid = 0; m_ovf = 0; m_sticky = 0; m_data = '0;
  endtask

  function automatic void mgrant(input bit md, input int s, input logic [3:0] v, input int p,
                                 output int g, output bit gv);
    g = 0; gv = 0;
    if (!md) begin
      g  = s;
      gv = (s < 4) && v[s[1:0]];
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (p + k) % 4;
        if (!gv && v[c[1:0]]) begin g = c; gv = 1; end
      end
    end
  endfunction

  // Called at posedge+1 with inputs already applied; returns at the following posedge+1.
  task automatic do_cycle(input string tag);
    int g; bit gv, ld; logic [3:0] er;
    mgrant(mode, int'(sel), in_valid, m_ptr, g, gv);
    ld = ((!m_valid) || out_ready) && gv;
    er = ld ? (4'b0001 << g) : 4'b0000;
    #1;
    last_rdy = in_ready;
    check({tag, "_rdy"}, 64'(in_ready), 64'(er));
    @(posedge clk);
    if (ld) begin
      m_data  = in_data[g*17 +: 16];
      m_ovf   = in_data[g*17 + 16];
      m_ch    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (ld && in_data[g*17 + 16]) begin
      m_sticky = 1;
      m_cnt    = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (ovf_clr) begin
      m_sticky = 0;
      m_cnt    = 0;
    end
    #1;
    $display("cycle %s: rdy=%b valid=%b ch=%0d data=%h ovf=%b sticky=%b cnt=%0d",
             tag, last_rdy, out_valid, out_ch, out_data, out_ovf, ovf_sticky, ovf_cnt);
    check({tag, "_out"}, 64'({out_valid, out_ch, out_ovf, out_data, ovf_sticky, ovf_cnt}),
          64'({m_valid, 2'(m_ch), m_ovf, m_data, m_sticky, 8'(m_cnt)}));
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
  task automatic reset_pulse(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst"}, 64'({out_valid, out_ch, out_ovf, out_data, ovf_sticky, ovf_cnt}), 64'd0);
    in_valid = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    t_data = '0; t_valid = '0; t_mode = 1'b0; t_sel = '0; t_out_ready = 1'b0; t_clr = 1'b0;
    model_reset();

    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h8000, 1'b1, 1};
    tbl[1]  = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h8000, 1'b1, 1};
    tbl[2]  = '{1'b0, 2'd2, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h8000, 1'b1, 1};
    tbl[3]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111, 1'b0, 1};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222, 1'b1, 2};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 16'h8000, 1'b1, 3};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444, 1'b0, 3};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 16'h1111, 1'b0, 3};
    tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222, 1'b1, 4};
    tbl[9]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 16'h4444, 1'b0, 4};
    tbl[10] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 16'h2222, 1'b1, 5};
    tbl[11] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'h2222, 1'b1, 5};
    rr_exp = '{0, 1, 2, 3, 0, 1};

    #2;
    check("init_rst", 64'({out_valid, out_ch, out_ovf, out_data, ovf_sticky, ovf_cnt}), 64'd0);
    check("init_rst3", 64'({t_out_valid, t_out_ch, t_out_ovf, t_out_data, t_sticky, t_cnt}), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    in_data = {17'h0_4444, 17'h1_8000, 17'h1_2222, 17'h0_1111};
    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].md; sel = tbl[i].s; in_valid = tbl[i].v; out_ready = tbl[i].ordy;
      do_cycle($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_rdy_exp", i), 64'(last_rdy), 64'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_out_exp", i),
            64'({out_valid, out_ch, out_ovf, out_data, ovf_sticky, ovf_cnt}),
            64'({tbl[i].e_ov, tbl[i].e_ch, tbl[i].e_ovf, tbl[i].e_data, 1'b1, 8'(tbl[i].e_cnt)}));
    end

    // Reset while stalled with a held result
    mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
    do_cycle("stall_a");
    do_cycle("stall_b");
    check("stall_valid", 64'(out_valid), 64'd1);
    reset_pulse("stall");

    // Round-robin from a fresh pointer, all channels valid
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_cycle($sformatf("rr%0d", i));
      check($sformatf("rr%0d_ch", i), 64'(out_ch), 64'(rr_exp[i]));
    end

    // Out-of-range fixed select on the 3-channel instance; main DUT kept idle
    in_valid = '0; out_ready = 1'b0;
    t_data = {9'h0_77, 9'h1_C3, 9'h0_5A};
    t_mode = 1'b0; t_sel = 2'd0; t_valid = 3'b111; t_out_ready = 1'b1;
    #1;
    check("n3_rdy_sel0", 64'(t_ready), 64'b001);
    @(posedge clk); #1;
    $display("n3 sel0: valid=%b ch=%0d data=%h", t_out_valid, t_out_ch, t_out_data);
    check("n3_out_sel0", 64'({t_out_valid, t_out_ch, t_out_data}), 64'({1'b1, 2'd0, 8'h5A}));
    t_sel = 2'd3;
    #1;
    check("n3_rdy_sel3", 64'(t_ready), 64'b000);
    @(posedge clk); #1;
    $display("n3 sel3: valid=%b", t_out_valid);
    check("n3_valid_sel3", 64'(t_out_valid), 64'd0);
    t_valid = '0; t_out_ready = 1'b0;

    // Counter saturation and clear priority
    reset_pulse("sat");
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    for (int i = 0; i < 260; i++) do_cycle($sformatf("sat%0d", i));
    check("sat_cnt", 64'(ovf_cnt), 64'd255);
    check("sat_sticky", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    do_cycle("clr_set");
    check("clr_set_val", 64'({ovf_sticky, ovf_cnt}), 64'({1'b1, 8'd1}));
    in_valid = 4'b0000;
    do_cycle("clr_only");
    check("clr_only_val", 64'({ovf_sticky, ovf_cnt}), 64'({1'b0, 8'd0}));
    ovf_clr = 1'b0;

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = {4'($urandom), $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      do_cycle($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
